// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Front-end for the panel push-buttons. Each button has its own channel:
//   raw pin -> 2-flop synchroniser -> debounce counter -> clean level
//   -> one-cycle press/release pulses -> hold FSM (long press, auto-repeat).
// All channels are independent and any number may be active at once.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   reset_n         asynchronous active-low reset, clears every flop
//   btn_raw         raw, bouncy, asynchronous button pins (active-high)
//   repeat_en       per-button auto-repeat enable (synchronous to clk)
//   btn_level       debounced button state
//   btn_pedge       one-cycle pulse when btn_level rises
//   btn_nedge       one-cycle pulse when btn_level falls
//   btn_long        one-cycle pulse when a hold reaches LONG_CYC cycles
//   btn_repeat      one-cycle pulse every REPEAT_CYC cycles after btn_long
//                   while held and repeat_en is set
//   dbg_hold_state  hold FSM state of button i on bits [2*i+1:2*i]
//                   (0 IDLE, 1 HELD, 2 LONG, 3 REPEAT)
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int N_BTN        = 7,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 100_000_000,
    parameter int REPEAT_CYC   = 20_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_BTN-1:0]   btn_raw,
    input  logic [N_BTN-1:0]   repeat_en,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_pedge,
    output logic [N_BTN-1:0]   btn_nedge,
    output logic [N_BTN-1:0]   btn_long,
    output logic [N_BTN-1:0]   btn_repeat,
    output logic [2*N_BTN-1:0] dbg_hold_state
);

    localparam int MAX_A = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
    localparam int MAX_P = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
    // One extra code point so the debounce terminal value DEBOUNCE_CYC fits
    // even when it is the largest parameter and a power of two.
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

    generate
        if (N_BTN < 2 || DEBOUNCE_CYC < 2 || LONG_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_params
            $error("btn_conditioner: every parameter must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_LONG   = 2'd2,
        S_REPEAT = 2'd3
    } hold_state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic            sync1_q, sync2_q;
        logic [CW-1:0]   db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            rise, fall;
        hold_state_e     state_q, state_d;
        logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
        logic            pedge_q, nedge_q, long_q, long_d, repeat_q, repeat_d;

        // Debounce: the count restarts whenever the synchronised pin agrees
        // with the accepted level, so any bounce throws away the progress.
        // Comparing against DEBOUNCE_CYC (not DEBOUNCE_CYC-1) places the
        // level change DEBOUNCE_CYC+2 edges after the pin is first sampled.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            if (sync2_q != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        assign rise = level_d & ~level_q;
        assign fall = ~level_d & level_q;

        // Hold FSM next state. A release wins over everything, which is what
        // keeps long/repeat pulses out of the release cycle.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
            if (fall) begin
                state_d    = S_IDLE;
                hold_cnt_d = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            state_d    = S_HELD;
                            hold_cnt_d = '0;
                        end
                    end
                    S_HELD: begin
                        if (hold_cnt_q == LONG_LAST) begin
                            long_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = S_LONG;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    S_LONG, S_REPEAT: begin
                        // Dropping repeat_en parks the counter at 0, so the
                        // period restarts from scratch when it comes back.
                        if (!repeat_en[i]) begin
                            hold_cnt_d = '0;
                        end else if (hold_cnt_q == REP_LAST) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = S_REPEAT;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d    = S_IDLE;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                db_cnt_q   <= '0;
                level_q    <= 1'b0;
                state_q    <= S_IDLE;
                hold_cnt_q <= '0;
                pedge_q    <= 1'b0;
                nedge_q    <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                sync1_q    <= btn_raw[i];
                sync2_q    <= sync1_q;
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                pedge_q    <= rise;
                nedge_q    <= fall;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
            end
        end

        assign btn_level[i]             = level_q;
        assign btn_pedge[i]             = pedge_q;
        assign btn_nedge[i]             = nedge_q;
        assign btn_long[i]              = long_q;
        assign btn_repeat[i]            = repeat_q;
        assign dbg_hold_state[2*i +: 2] = state_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Bench for btn_conditioner with short timing parameters. Every output pulse
// is turned into an event word {cycle, button, kind}; the expected words are
// derived from the press/release times at the moment the stimulus is planned
// and kept sorted in exp_q, and the monitor pops one per observed pulse.
// The debounced level of every active button is also checked each cycle.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int N   = 7;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;
    localparam int LAT = DEB + 2;   // first-sample edge to level change

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   btn_raw;
    logic [N-1:0]   repeat_en;
    logic [N-1:0]   btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat;
    logic [2*N-1:0] dbg_hold_state;

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_conditioner #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LNG),
        .REPEAT_CYC   (REP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .btn_raw        (btn_raw),
        .repeat_en      (repeat_en),
        .btn_level      (btn_level),
        .btn_pedge      (btn_pedge),
        .btn_nedge      (btn_nedge),
        .btn_long       (btn_long),
        .btn_repeat     (btn_repeat),
        .dbg_hold_state (dbg_hold_state)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // kind: 0 pedge, 1 nedge, 2 long, 3 repeat
    function automatic logic [31:0] evt(input int c, input int b, input int k);
        return 32'((c << 5) | (b << 2) | k);
    endfunction

    task automatic push_exp(input logic [31:0] w);
        int i;
        i = 0;
        while (i < exp_q.size() && exp_q[i] <= w) i++;
        exp_q.insert(i, w);
    endtask

    // Monitor: iterate button then kind, matching the event word ordering.
    always @(negedge clk) begin
        logic [3:0]  pulses;
        logic [31:0] w;
        for (int b = 0; b < N; b++) begin
            pulses = {btn_repeat[b], btn_long[b], btn_nedge[b], btn_pedge[b]};
            for (int k = 0; k < 4; k++) begin
                if (pulses[k]) begin
                    w = evt(cyc, b, k);
                    if (exp_q.size() == 0) check("spurious_evt", w, 64'd0);
                    else                   check("event", w, exp_q.pop_front());
                end
            end
            if (btn_pedge[b]) check("pedge_level", btn_level[b], 1);
            if (btn_nedge[b]) check("nedge_level", btn_level[b], 0);
        end
    end

    // ---------------- driver ----------------
    int rise_at[N];
    int fall_at[N];
    bit bnc[N];

    task automatic clear_plan();
        for (int b = 0; b < N; b++) begin
            rise_at[b] = -1;
            fall_at[b] = -1;
            bnc[b]     = 1'b0;
        end
    endtask

    // Called on a negedge; step t is first sampled at edge base+t.
    task automatic run(input int len);
        int base;
        int p_at[N];
        int n_at[N];
        base = cyc + 1;
        for (int b = 0; b < N; b++) begin
            if (rise_at[b] >= 0) begin
                p_at[b] = base + rise_at[b] + LAT;
                n_at[b] = base + fall_at[b] + LAT;
                push_exp(evt(p_at[b], b, 0));
                push_exp(evt(n_at[b], b, 1));
                if (n_at[b] - p_at[b] > LNG) begin
                    push_exp(evt(p_at[b] + LNG, b, 2));
                    if (repeat_en[b]) begin
                        for (int c = p_at[b] + LNG + REP; c < n_at[b]; c += REP)
                            push_exp(evt(c, b, 3));
                    end
                end
            end
        end
        for (int t = 0; t < len; t++) begin
            for (int b = 0; b < N; b++) begin
                if (rise_at[b] >= 0) begin
                    if (bnc[b] && t < rise_at[b]) btn_raw[b] = (t % 2 == 0);
                    else                          btn_raw[b] = (t >= rise_at[b] && t < fall_at[b]);
                end
            end
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if (rise_at[b] >= 0)
                    check("level", btn_level[b], (cyc >= p_at[b] && cyc < n_at[b]));
            end
        end
        clear_plan();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        reset_n   = 1'b0;
        btn_raw   = '0;
        repeat_en = '0;
        clear_plan();

        repeat (3) @(negedge clk);
        check("reset_outputs", {btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat}, 64'd0);
        check("reset_state", dbg_hold_state, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean short press on 0, bouncy press on 2.
        rise_at[0] = 0; fall_at[0] = 8;
        rise_at[2] = 4; fall_at[2] = 14; bnc[2] = 1'b1;
        run(30);

        // Long press with repeat on 1, long press without repeat on 3.
        repeat_en  = 7'b0000010;
        rise_at[1] = 0; fall_at[1] = 60;
        rise_at[3] = 0; fall_at[3] = 40;
        run(75);

        // Simultaneous press on 4 and 5; 4 released early, 5 keeps going.
        repeat_en  = 7'b0100000;
        rise_at[4] = 0; fall_at[4] = 10;
        rise_at[5] = 0; fall_at[5] = 40;
        run(55);
        repeat_en  = '0;

        // Reset pulsed while button 6 is in the middle of a hold.
        c0 = cyc;
        btn_raw[6] = 1'b1;
        push_exp(evt(c0 + 1 + LAT, 6, 0));
        repeat (12) @(negedge clk);
        check("held_level", btn_level[6], 1);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset_outputs", {btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat}, 64'd0);
            check("midreset_state", dbg_hold_state, 64'd0);
        end
        reset_n = 1'b1;
        push_exp(evt(cyc + 1 + LAT, 6, 0));
        repeat (10) @(negedge clk);
        btn_raw[6] = 1'b0;
        push_exp(evt(cyc + 1 + LAT, 6, 1));
        repeat (15) @(negedge clk);

        // ---------------- report ----------------
        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) check("missing_evt", 64'd0, exp_q.pop_front());
        check("final_idle", {btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat}, 64'd0);
        check("final_state", dbg_hold_state, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
